// File: rtl/grid_param_sender.sv
// grid_param_sender: walks an (m, r) grid and streams value = m + r + 0.5
// in unsigned fixed point over valid/ready, one sweep per start pulse.
// Ports: clk/rst (async, active-high); start; out_valid/out_ready/out_data,
// out_m_idx, out_r_idx, out_last stream; busy (sweep in progress); done pulse.
// Latency: first beat is visible right after the edge that samples start;
// one beat per cycle with out_ready held high.
// Backpressure: every stream output is held while out_valid && !out_ready.
// Optional feature macro: GRID_SENDER_CHECKSUM_EN appends a SUM beat
// (modular sum of all grid beats, indices 8'hFF, out_last=1).
module grid_param_sender #(
  parameter int M_START   = 10,
  parameter int M_END     = 20,
  parameter int M_STEP    = 10,
  parameter int R_COUNT   = 2,
  parameter int FRAC_BITS = 8,
  parameter int WIDTH     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       out_m_idx,
  output logic [7:0]       out_r_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  // Elaboration-time parameter sanity.
  if (M_STEP < 1 || R_COUNT < 1 || FRAC_BITS < 1) begin : g_bad_param
    $error("grid_param_sender: M_STEP, R_COUNT and FRAC_BITS must all be >= 1");
  end
  if (((longint'(M_END) + longint'(R_COUNT)) << FRAC_BITS) > (longint'(1) << WIDTH))
  begin : g_overflow
    $error("grid_param_sender: (M_END+R_COUNT)<<FRAC_BITS overflows WIDTH");
  end

  // A grid whose first point is also its last point (single m, single r).
  localparam bit FIRST_IS_LAST =
    (R_COUNT == 1) && ((longint'(M_START) + longint'(M_STEP)) > longint'(M_END));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_SUM  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      m_q;
  logic [31:0]      r_q;
  logic [7:0]       m_idx_q;
  logic [WIDTH-1:0] data_q;
  logic             grid_last_q;   // beat currently held is the last grid point
`ifdef GRID_SENDER_CHECKSUM_EN
  logic [WIDTH-1:0] sum_q;
`endif

  logic        fire;
  logic        r_at_end;
  logic [31:0] m_n;
  logic [31:0] r_n;
  logic [7:0]  m_idx_n;
  logic        last_n;

  function automatic logic [WIDTH-1:0] beat_value(input logic [31:0] m, input logic [31:0] r);
    beat_value = WIDTH'(((64'(m) + 64'(r)) << FRAC_BITS) | (64'd1 << (FRAC_BITS - 1)));
  endfunction

  assign fire = out_valid && out_ready;

  // Next grid point, r inner and m outer. The "is this the last m" test
  // uses m + M_STEP > M_END in 33 bits so the counter can never wrap.
  always_comb begin
    r_at_end = (r_q == 32'(R_COUNT - 1));
    m_n      = r_at_end ? (m_q + 32'(M_STEP)) : m_q;
    r_n      = r_at_end ? 32'd0 : (r_q + 32'd1);
    m_idx_n  = r_at_end ? (m_idx_q + 8'd1) : m_idx_q;
    last_n   = (r_n == 32'(R_COUNT - 1)) &&
               (({1'b0, m_n} + 33'(M_STEP)) > 33'(M_END));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_SEND;
      S_SEND: begin
        if (fire && grid_last_q) begin
`ifdef GRID_SENDER_CHECKSUM_EN
          state_d = S_SUM;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef GRID_SENDER_CHECKSUM_EN
      S_SUM:  if (fire) state_d = S_DONE;
`else
      S_SUM:  state_d = S_IDLE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode. Everything here is a function of registers only, so the
  // stream has no combinational path from out_ready or start.
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    out_data  = '0;
    out_m_idx = 8'd0;
    out_r_idx = 8'd0;
    out_last  = 1'b0;
    case (state_q)
      S_SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = data_q;
        out_m_idx = m_idx_q;
        out_r_idx = r_q[7:0];
`ifdef GRID_SENDER_CHECKSUM_EN
        out_last  = 1'b0;
`else
        out_last  = grid_last_q;
`endif
      end
`ifdef GRID_SENDER_CHECKSUM_EN
      S_SUM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = sum_q;
        out_m_idx = 8'hFF;
        out_r_idx = 8'hFF;
        out_last  = 1'b1;
      end
`endif
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Grid walker and beat register. The beat for the next point is computed
  // on acceptance so out_data is always straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q         <= 32'(M_START);
      r_q         <= 32'd0;
      m_idx_q     <= 8'd0;
      data_q      <= '0;
      grid_last_q <= 1'b0;
`ifdef GRID_SENDER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            m_q         <= 32'(M_START);
            r_q         <= 32'd0;
            m_idx_q     <= 8'd0;
            data_q      <= beat_value(32'(M_START), 32'd0);
            grid_last_q <= FIRST_IS_LAST;
`ifdef GRID_SENDER_CHECKSUM_EN
            sum_q       <= '0;
`endif
          end
        end
        S_SEND: begin
          if (fire) begin
`ifdef GRID_SENDER_CHECKSUM_EN
            sum_q <= sum_q + data_q;
`endif
            if (!grid_last_q) begin
              m_q         <= m_n;
              r_q         <= r_n;
              m_idx_q     <= m_idx_n;
              data_q      <= beat_value(m_n, r_n);
              grid_last_q <= last_n;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
